// File: rtl/axis_arb_pkg.sv
// Shared types and helper functions for the round-robin AXI4-Stream packet arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Helper functions work on the widest supported configuration (16 sources).
    localparam int unsigned MAX_SRC  = 16;
    localparam int unsigned MAX_ID_W = 4;

    // First requester strictly after 'last', wrapping modulo 'num'; returns 'last' if none.
    function automatic logic [MAX_ID_W-1:0] rr_pick(input logic [MAX_SRC-1:0]  req,
                                                    input logic [MAX_ID_W-1:0] last,
                                                    input int unsigned          num);
        logic [MAX_ID_W-1:0] pick;
        logic [MAX_ID_W:0]   cand;
        logic                found;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_SRC; k++) begin
            // last < num and k <= num, so one conditional subtract is a full modulo
            cand = {1'b0, last} + 5'(k);
            if (cand >= 5'(num)) begin
                cand = cand - 5'(num);
            end
            if (k <= num && !found && req[cand[MAX_ID_W-1:0]]) begin
                pick  = cand[MAX_ID_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [MAX_SRC-1:0] onehot(input logic [MAX_ID_W-1:0] idx);
        logic [MAX_SRC-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer; all outputs come from registers and ready depends only on
// the fill level, so no combinational path crosses it in either direction.
module axis_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem_q [2];
    logic [1:0]   count_q;
    logic         rd_q;
    logic         wr_q;
    logic         push;
    logic         pop;

    // Handshakes and registered outputs
    always_comb begin
        in_ready  = (count_q != 2'd2);
        out_valid = (count_q != 2'd0);
        out_data  = mem_q[rd_q];
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Storage, pointers and fill level; reset empties the buffer
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= 2'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= in_data;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/axis_rr_pkt_arbiter.sv
// N-to-1 AXI4-Stream arbiter, round-robin at packet granularity. A grant is held
// from the first beat until the TLAST beat is accepted.
// Define AXIS_RR_PKT_ARBITER_OUT_REG_EN to register the m_axis side through a
// 2-entry skid buffer; otherwise the granted source passes straight through.
module axis_rr_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int unsigned NUM_SRC = 4,
    parameter  int unsigned DATA_W  = 32,
    localparam int unsigned ID_W    = $clog2(NUM_SRC)
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [NUM_SRC-1:0]          s_axis_tvalid,
    output logic [NUM_SRC-1:0]          s_axis_tready,
    input  logic [NUM_SRC*DATA_W-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]          s_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic [ID_W-1:0]             m_axis_tid,
    output logic [NUM_SRC-1:0]          grant
);

    arb_state_t          state_q, state_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]     idx_q, idx_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic                locked;
    logic                src_valid;
    logic                src_last;
    logic [DATA_W-1:0]   src_data;
    logic                pkt_end;

    // Signals of the currently granted source
    always_comb begin
        locked    = (state_q == LOCKED);
        src_valid = s_axis_tvalid[idx_q];
        src_last  = s_axis_tlast[idx_q];
        src_data  = s_axis_tdata[idx_q*DATA_W +: DATA_W];
        grant     = grant_q;
    end

`ifdef AXIS_RR_PKT_ARBITER_OUT_REG_EN
    logic skid_ready;
    logic push;

    // Upstream ready depends only on the skid fill level; packet end seen on input side
    always_comb begin
        push          = locked & src_valid & skid_ready;
        pkt_end       = push & src_last;
        s_axis_tready = grant_q & {NUM_SRC{skid_ready}};
    end

    axis_skid_buf #(
        .W(DATA_W + 1 + ID_W)
    ) u_skid (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .in_valid (push),
        .in_ready (skid_ready),
        .in_data  ({src_data, src_last, idx_q}),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready),
        .out_data ({m_axis_tdata, m_axis_tlast, m_axis_tid})
    );
`else
    // Zero-latency pass-through of the granted source; outputs idle at zero
    always_comb begin
        m_axis_tvalid = locked & src_valid;
        m_axis_tdata  = locked ? src_data : '0;
        m_axis_tlast  = locked & src_last;
        m_axis_tid    = locked ? idx_q : '0;
        // grant_q is zero when idle, so this also keeps all readies low in IDLE
        s_axis_tready = grant_q & {NUM_SRC{m_axis_tready}};
        pkt_end       = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    end
`endif

    // Arbitration FSM next state: pick on any request in IDLE, release on packet end
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    idx_d   = ID_W'(rr_pick(MAX_SRC'(s_axis_tvalid), MAX_ID_W'(last_q),
                                            NUM_SRC));
                    grant_d = NUM_SRC'(onehot(rr_pick(MAX_SRC'(s_axis_tvalid),
                                                      MAX_ID_W'(last_q), NUM_SRC)));
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (pkt_end) begin
                    last_d  = idx_q;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; after reset source 0 has top priority
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= ID_W'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// Directed self-checking bench for axis_rr_pkt_arbiter (pass-through build).
module tb_axis_rr_pkt_arbiter;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ID_W    = 2;

    logic                      aclk = 1'b0;
    logic                      aresetn;
    logic [NUM_SRC-1:0]        s_axis_tvalid;
    logic [NUM_SRC-1:0]        s_axis_tready;
    logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
    logic [NUM_SRC-1:0]        s_axis_tlast;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;
    logic [DATA_W-1:0]         m_axis_tdata;
    logic                      m_axis_tlast;
    logic [ID_W-1:0]           m_axis_tid;
    logic [NUM_SRC-1:0]        grant;

    always #5 aclk = ~aclk;

    axis_rr_pkt_arbiter #(
        .NUM_SRC(NUM_SRC),
        .DATA_W (DATA_W)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tid   (m_axis_tid),
        .grant        (grant)
    );

    logic [32:0]  src_q [NUM_SRC][$];
    logic [3:0]   hold;
    logic [3:0]   hs;
    logic         rdy_osc;
    int           cyc;
    logic [31:0]  out_data [$];
    logic [1:0]   out_tid [$];
    logic         out_last [$];
    int           out_cyc [$];
    int           n_checks;
    int           n_errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int src, input logic last, input logic [31:0] data);
        src_q[src].push_back({last, data});
    endtask

    task automatic drive();
        logic [32:0] b;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                s_axis_tvalid[i]         = ~hold[i];
                s_axis_tlast[i]          = b[32];
                s_axis_tdata[i*32 +: 32] = b[31:0];
            end else begin
                s_axis_tvalid[i]         = 1'b0;
                s_axis_tlast[i]          = 1'b0;
                s_axis_tdata[i*32 +: 32] = '0;
            end
        end
        m_axis_tready = rdy_osc ? ((cyc % 5) < 3) : 1'b1;
    endtask

    // Called 4 time units after a rising edge; returns at the same phase of the next cycle
    task automatic tick();
        hs = aresetn ? (s_axis_tvalid & s_axis_tready) : 4'b0000;
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            out_data.push_back(m_axis_tdata);
            out_tid.push_back(m_axis_tid);
            out_last.push_back(m_axis_tlast);
            out_cyc.push_back(cyc);
        end
        @(posedge aclk);
        cyc++;
        #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hs[i] && src_q[i].size() > 0) src_q[i].delete(0);
        end
        drive();
        #3;
    endtask

    task automatic clear_out();
        out_data.delete();
        out_tid.delete();
        out_last.delete();
        out_cyc.delete();
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (out_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(out_data.size()), 64'(n));
    endtask

    task automatic reset_dut();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        cyc           = 0;
        hold          = '0;
        hs            = '0;
        rdy_osc       = 1'b0;
        aresetn       = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        @(posedge aclk);
        #4;
        reset_dut();

        // Reset state
        check("rst_valid", 64'(m_axis_tvalid), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_ready", 64'(s_axis_tready), 64'd0);
        check("rst_data", 64'(m_axis_tdata), 64'd0);
        check("rst_last", 64'(m_axis_tlast), 64'd0);
        check("rst_tid", 64'(m_axis_tid), 64'd0);

        // T1: source 1 alone, 3 beats, one idle bubble first
        clear_out();
        load(1, 1'b0, 32'hA1);
        load(1, 1'b0, 32'hA2);
        load(1, 1'b1, 32'hA3);
        drive();
        check("t1_bubble_valid", 64'(m_axis_tvalid), 64'd0);
        check("t1_bubble_ready", 64'(s_axis_tready), 64'd0);
        tick();
        check("t1_grant", 64'(grant), 64'h2);
        check("t1_valid", 64'(m_axis_tvalid), 64'd1);
        check("t1_data0", 64'(m_axis_tdata), 64'hA1);
        check("t1_tid", 64'(m_axis_tid), 64'd1);
        check("t1_ready", 64'(s_axis_tready), 64'h2);
        tick();
        check("t1_data1", 64'(m_axis_tdata), 64'hA2);
        check("t1_last1", 64'(m_axis_tlast), 64'd0);
        tick();
        check("t1_data2", 64'(m_axis_tdata), 64'hA3);
        check("t1_last2", 64'(m_axis_tlast), 64'd1);
        tick();
        check("t1_grant_end", 64'(grant), 64'd0);
        check("t1_valid_end", 64'(m_axis_tvalid), 64'd0);
        check("t1_beats", 64'(out_data.size()), 64'd3);
        check("t1_span", 64'(out_cyc[2] - out_cyc[0]), 64'd2);

        // T2: all four sources at once after reset -> order 0,1,2,3 with one bubble
        reset_dut();
        clear_out();
        for (int i = 0; i < NUM_SRC; i++) begin
            load(i, 1'b0, 32'h100 * i);
            load(i, 1'b1, 32'h100 * i + 1);
        end
        drive();
        wait_beats("t2_timeout", 8, 60);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t2_tid%0d", k), 64'(out_tid[k]), 64'(k / 2));
            check($sformatf("t2_data%0d", k), 64'(out_data[k]), 64'(32'h100 * (k / 2) + k % 2));
            check($sformatf("t2_last%0d", k), 64'(out_last[k]), 64'(k % 2));
            check($sformatf("t2_cyc%0d", k), 64'(out_cyc[k] - out_cyc[0]),
                  64'(3 * (k / 2) + k % 2));
        end

        // T3: source 2, five single-beat packets -> one beat every other cycle
        clear_out();
        for (int k = 0; k < 5; k++) load(2, 1'b1, 32'h51 + k);
        drive();
        wait_beats("t3_timeout", 5, 40);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_data%0d", k), 64'(out_data[k]), 64'(32'h51 + k));
            check($sformatf("t3_tid%0d", k), 64'(out_tid[k]), 64'd2);
            check($sformatf("t3_cyc%0d", k), 64'(out_cyc[k] - out_cyc[0]), 64'(2 * k));
        end

        // T4: downstream ready 3 high / 2 low, source 0 sends 8 beats
        clear_out();
        rdy_osc = 1'b1;
        for (int k = 0; k < 8; k++) load(0, k == 7, 32'h61 + k);
        drive();
        for (int k = 0; k < 80 && out_data.size() < 8; k++) begin
            tick();
            if (grant == 4'b0001) begin
                check("t4_ready_mirror", 64'(s_axis_tready), 64'({3'b000, m_axis_tready}));
            end
        end
        check("t4_timeout", 64'(out_data.size()), 64'd8);
        tick();
        tick();
        tick();
        check("t4_no_dup", 64'(out_data.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t4_data%0d", k), 64'(out_data[k]), 64'(32'h61 + k));
            check($sformatf("t4_last%0d", k), 64'(out_last[k]), 64'(k == 7));
        end
        rdy_osc = 1'b0;
        drive();

        // T5: source 3 stalls mid-packet; source 0 must stay blocked
        clear_out();
        load(3, 1'b0, 32'hB1);
        load(3, 1'b0, 32'hB2);
        load(3, 1'b1, 32'hB3);
        drive();
        tick();
        check("t5_grant3", 64'(grant), 64'h8);
        load(0, 1'b1, 32'hC1);
        drive();
        tick();
        hold[3] = 1'b1;
        drive();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_hold_ready0", 64'(s_axis_tready[0]), 64'd0);
            check("t5_hold_valid", 64'(m_axis_tvalid), 64'd0);
            check("t5_hold_grant", 64'(grant), 64'h8);
        end
        hold[3] = 1'b0;
        drive();
        for (int k = 0; k < 30 && out_data.size() < 4; k++) begin
            if (grant[3]) check("t5_ready0_blocked", 64'(s_axis_tready[0]), 64'd0);
            tick();
        end
        check("t5_timeout", 64'(out_data.size()), 64'd4);
        check("t5_tid0", 64'(out_tid[0]), 64'd3);
        check("t5_data1", 64'(out_data[1]), 64'hB2);
        check("t5_tid2", 64'(out_tid[2]), 64'd3);
        check("t5_data2", 64'(out_data[2]), 64'hB3);
        check("t5_tid3", 64'(out_tid[3]), 64'd0);
        check("t5_data3", 64'(out_data[3]), 64'hC1);

        // T6: reset mid-packet from source 1; priority returns to source 0 first
        clear_out();
        load(2, 1'b1, 32'hF1);
        drive();
        wait_beats("t6_pre_timeout", 1, 10);
        clear_out();
        for (int k = 0; k < 4; k++) load(1, k == 3, 32'hD1 + k);
        drive();
        wait_beats("t6_pkt_timeout", 1, 10);
        aresetn = 1'b0;
        tick();
        check("t6_rst_valid", 64'(m_axis_tvalid), 64'd0);
        check("t6_rst_grant", 64'(grant), 64'd0);
        check("t6_rst_ready", 64'(s_axis_tready), 64'd0);
        check("t6_rst_data", 64'(m_axis_tdata), 64'd0);
        check("t6_rst_last", 64'(m_axis_tlast), 64'd0);
        check("t6_rst_tid", 64'(m_axis_tid), 64'd0);
        for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
        aresetn = 1'b1;
        clear_out();
        load(2, 1'b1, 32'hE1);
        load(3, 1'b1, 32'h71);
        drive();
        wait_beats("t6_post_timeout", 2, 20);
        check("t6_first_tid", 64'(out_tid[0]), 64'd2);
        check("t6_first_data", 64'(out_data[0]), 64'hE1);
        check("t6_second_tid", 64'(out_tid[1]), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_rr_pkt_arbiter.md
Name: axis_rr_pkt_arbiter

Overview:
- N-to-1 AXI4-Stream packet arbiter. Shares one downstream AXI4-Stream slave (VIP or DMA sink) between NUM_SRC upstream masters.
- Uses round-robin arbitration at packet granularity. A grant is held from the first beat until the beat carrying TLAST is accepted, so packets are never interleaved.
- Sits between stream producers and the shared sink in the block design.

Parameters:
- NUM_SRC, 4, number of upstream sources (2..16).
- DATA_W, 32, TDATA width in bits (multiple of 8).
- ID_W, $clog2(NUM_SRC), width of the source-index output (localparam, not overridable).

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- aresetn  in  1  reset; synchronous, active-low.
- s_axis_tvalid  in  NUM_SRC  per-source TVALID.
- s_axis_tready  out  NUM_SRC  per-source TREADY.
- s_axis_tdata  in  NUM_SRC*DATA_W  per-source TDATA; source i occupies bits [i*DATA_W +: DATA_W].
- s_axis_tlast  in  NUM_SRC  per-source TLAST.
- m_axis_tvalid  out  1  downstream TVALID.
- m_axis_tready  in  1  downstream TREADY.
- m_axis_tdata  out  DATA_W  downstream TDATA.
- m_axis_tlast  out  1  downstream TLAST.
- m_axis_tid  out  ID_W  index of the source that owns the current beat.
- grant  out  NUM_SRC  one-hot current owner; all zero when idle.

Behaviour:
- Reset (aresetn=0 at a clock edge):
  - state=IDLE; grant=0; last_grant=NUM_SRC-1, so source 0 has highest priority first.
  - m_axis_tvalid=0; s_axis_tready=0; m_axis_tdata/tlast/tid=0.
- FSM states are IDLE and LOCKED.
- IDLE:
  - s_axis_tready all 0; m_axis_tvalid=0.
  - If any s_axis_tvalid is high, pick the first requester scanning from last_grant+1 upward, wrapping modulo NUM_SRC.
  - At the next edge: grant=onehot(sel), state=LOCKED.
  - This is a fixed 1-cycle arbitration bubble per packet.
- LOCKED, with granted index g:
  - m_axis_tvalid=s_axis_tvalid[g]; m_axis_tdata/tlast come from source g; m_axis_tid=g.
  - s_axis_tready[g]=m_axis_tready; all other s_axis_tready=0.
  - This path is combinational, so there is zero data latency.
- Packet end: on m_axis_tvalid & m_axis_tready & m_axis_tlast, the next state is IDLE, last_grant=g, grant=0.
- Granted source drops tvalid mid-packet: the lock is held indefinitely; no timeout.
- Requests from non-granted sources mid-packet are ignored and never interleaved.
- Single requester: it is re-granted after the bubble, giving ≤50% throughput for 1-beat packets.
- A requester that drops tvalid during IDLE before the grant edge is still granted. LOCKED then waits for its tvalid.
- No path from any TREADY to any TVALID, per the AXI4-Stream rule.
- Reset mid-packet: the packet is abandoned and the FSM returns to IDLE. Upstream and downstream must also be reset; no recovery is attempted.

Optional Feature:
- Macro: AXIS_RR_PKT_ARBITER_OUT_REG_EN.
- Defined:
  - The m_axis side is driven from a 2-entry skid buffer. All m_axis outputs are registered, adding 1 cycle of latency.
  - Full throughput is kept under continuous ready.
  - s_axis_tready[g] = LOCKED & skid not full; no combinational ready path crosses the block.
  - Packet-end detection uses the input-side handshake (s valid&ready&tlast of source g).
  - The skid buffer empties on reset.
- Undefined: combinational pass-through as described above.

Decomposition:
- Package axis_arb_pkg:
  - typedef enum logic {IDLE, LOCKED} arb_state_t.
  - Function rr_pick(req, last), returning the next index.
  - Function onehot(idx).
- Sub-module axis_skid_buf (DATA_W+1+ID_W payload): instantiated only under AXIS_RR_PKT_ARBITER_OUT_REG_EN.

Test Plan:
- Source 1 alone sends a 3-beat packet 0xA1,0xA2,0xA3 (tlast on beat 3), m_axis_tready=1 → 1 idle cycle, then 3 consecutive output beats with tid=1, then grant=0.
- Sources 0..3 each present a 2-beat packet in the same cycle after reset → output packet order 0,1,2,3; each packet contiguous; one bubble cycle between packets.
- Source 2 sends 5 back-to-back single-beat packets, tready constantly 1 → outputs every other cycle (bubble between grants); all 5 data values in order.
- Downstream ready oscillates 3 cycles high / 2 low; source 0 sends 8 beats → 8 beats out in order, none duplicated or dropped; source TREADY mirrors m_axis_tready.
- Source 3 holds a packet mid-stream (tvalid low 4 cycles) while source 0 requests → source 0 receives no tready until source 3's TLAST beat is accepted.
- aresetn pulled low for 1 cycle mid-packet from source 1 → next cycle all outputs at reset values. A new request from source 2 is then granted (source 0 priority restored).
